// File: rtl/serial_product_collector.sv
// serial_product_collector: assembles an LSB-first serial product into a parallel word (optional parity via SPC_PARITY_EN)
module serial_product_collector #(
  parameter int WIDTH = 8,
  parameter int SKIP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_in,
  input  logic               ready,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               busy
`ifdef SPC_PARITY_EN
  ,
  output logic               parity
`endif
);
  localparam int PW = 2 * WIDTH;
  localparam int BW = $clog2(PW) + 1;
  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, HOLD} state_t;
  localparam state_t FIRST = (SKIP == 0) ? SHIFT : ALIGN;
  localparam logic [3:0] ALIGN_INIT = 4'(SKIP == 0 ? 0 : SKIP - 1);
  localparam logic [BW-1:0] LAST = BW'(PW - 1);
  state_t state;
  logic [3:0] align_cnt;
  logic [BW-1:0] bit_cnt;
  logic accept;
  assign accept = start && (state == IDLE || (state == HOLD && ready));
  assign busy = state != IDLE;
  // Capture sequencer: align past upstream latency, shift in 2*WIDTH bits, hold until handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      product   <= '0;
      valid     <= 1'b0;
      align_cnt <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      state     <= FIRST;
      valid     <= 1'b0;
      align_cnt <= ALIGN_INIT;
      bit_cnt   <= '0;
    end else begin
      case (state)
        ALIGN: begin
          if (align_cnt == 0) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end else align_cnt <= align_cnt - 1'b1;
        end
        SHIFT: begin
          product <= {s_in, product[PW-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            state <= HOLD;
            valid <= 1'b1;
          end
        end
        HOLD: begin
          if (ready) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPC_PARITY_EN
  // Running XOR of every shifted bit, restarted with each accepted capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else if (accept) parity <= 1'b0;
    else if (state == SHIFT) parity <= parity ^ s_in;
  end
`endif
endmodule

// File: tb/tb_serial_product_collector.sv
// tb_serial_product_collector: directed scoreboard bench for serial_product_collector (SKIP=1 and SKIP=0 instances)
module tb_serial_product_collector;
  logic clk = 0, rst = 0, start = 0, s_in = 0, ready = 0;
  logic [7:0] p1, p0;
  logic v1, v0, b1, b0;
`ifdef SPC_PARITY_EN
  logic par1, par0;
`endif
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] last = 0;

  always #5 clk = ~clk;

  serial_product_collector #(.WIDTH(4), .SKIP(1)) d1 (
    .clk(clk), .rst(rst), .start(start), .s_in(s_in), .ready(ready),
    .product(p1), .valid(v1), .busy(b1)
`ifdef SPC_PARITY_EN
    , .parity(par1)
`endif
  );
  serial_product_collector #(.WIDTH(4), .SKIP(0)) d0 (
    .clk(clk), .rst(rst), .start(start), .s_in(s_in), .ready(ready),
    .product(p0), .valid(v0), .busy(b0)
`ifdef SPC_PARITY_EN
    , .parity(par0)
`endif
  );

  function automatic logic [7:0] prod(input int sel);
    return sel != 0 ? p1 : p0;
  endfunction
  function automatic logic vld(input int sel);
    return sel != 0 ? v1 : v0;
  endfunction
  function automatic logic bsy(input int sel);
    return sel != 0 ? b1 : b0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cap(input int sel, input logic [7:0] v, input bit hs, input int mid);
    q.push_back(v);
    start = 1; s_in = 0;
    if (hs) ready = 1;
    @(posedge clk); #1;
    start = 0; ready = 0;
    chk("busy_after_start", 16'(bsy(sel)), 16'd1);
    chk("valid_after_start", 16'(vld(sel)), 16'd0);
    if (hs) chk("product_kept", 16'(prod(sel)), 16'(last));
    repeat (sel) begin @(posedge clk); #1; end
    for (int j = 0; j < 8; j++) begin
      s_in = v[j];
      start = (j == mid);
      if (j == 7) chk("valid_low_shift", 16'(vld(sel)), 16'd0);
      @(posedge clk); #1;
    end
    start = 0; s_in = 0;
  endtask

  task automatic result(input int sel);
    int n = 0;
    logic [7:0] e;
    while (!vld(sel) && n < 40) begin @(posedge clk); #1; n++; end
    chk("valid_latency", 16'(n), 16'd0);
    chk("valid_high", 16'(vld(sel)), 16'd1);
    if (q.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
      return;
    end
    e = q.pop_front();
    chk("product", 16'(prod(sel)), 16'(e));
`ifdef SPC_PARITY_EN
    chk("parity", 16'(sel != 0 ? par1 : par0), 16'(^e));
`endif
    last = e;
  endtask

  task automatic handshake(input int sel);
    ready = 1;
    @(posedge clk); #1;
    ready = 0;
    chk("valid_after_hs", 16'(vld(sel)), 16'd0);
    chk("busy_after_hs", 16'(bsy(sel)), 16'd0);
  endtask

  initial begin
    #2 rst = 1;
    #1;
    chk("rst_product", 16'(p1), 16'd0);
    chk("rst_valid", 16'(v1), 16'd0);
    chk("rst_busy", 16'(b1), 16'd0);
    @(posedge clk); #7 rst = 0;
    @(posedge clk); #1;
    chk("idle_busy", 16'(b1), 16'd0);
    // basic capture and held result under backpressure
    cap(1, 8'hB4, 0, -1);
    result(1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_product", 16'(p1), 16'hB4);
      chk("hold_valid", 16'(v1), 16'd1);
      chk("hold_busy", 16'(b1), 16'd1);
    end
    handshake(1);
    // start pulsed mid-shift is ignored
    cap(1, 8'h5A, 0, 3);
    result(1);
    handshake(1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 11) begin
        chk("no_second_valid", 16'(v1), 16'd0);
        chk("no_second_busy", 16'(b1), 16'd0);
      end
    end
    // parity pattern with odd weight
    cap(1, 8'hB5, 0, -1);
    result(1);
    handshake(1);
    // asynchronous reset in the middle of a capture
    start = 1; s_in = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_product", 16'(p1), 16'd0);
    chk("midrst_valid", 16'(v1), 16'd0);
    chk("midrst_busy", 16'(b1), 16'd0);
    #2 rst = 0; s_in = 0;
    @(posedge clk); #1;
    cap(1, 8'hFF, 0, -1);
    result(1);
    handshake(1);
    // SKIP=0 back-to-back: handshake and new start at the same edge
    rst = 1; #2 rst = 0;
    @(posedge clk); #1;
    cap(0, 8'hA5, 0, -1);
    result(0);
    cap(0, 8'h01, 1, -1);
    result(0);
    handshake(0);
    chk("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
